// File: rtl/rv_pkg.sv
// Shared types for the OP-IMM fetch/decode front end.
// Decoded-instruction bundle, funct3 codes and fetch FSM states.
package rv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [2:0] {
        F3_ADDI      = 3'b000,
        F3_SLLI      = 3'b001,
        F3_SLTI      = 3'b010,
        F3_SLTIU     = 3'b011,
        F3_XORI      = 3'b100,
        F3_SRLI_SRAI = 3'b101,
        F3_ORI       = 3'b110,
        F3_ANDI      = 3'b111
    } funct3_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        funct3_e     funct3;
        logic [31:0] imm;
        logic        is_itype;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/i_field_decode.sv
// Combinational OP-IMM field extraction and shift-encoding check.
// The pc field is left zero; the parent fills it in when capturing.
module i_field_decode
    import rv_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_fields
);

    logic [6:0] w_f7;
    funct3_e    w_f3;
    logic       w_is_itype;
    logic       w_bad_shift;

    assign w_f7       = i_instr[31:25];
    assign w_f3       = funct3_e'(i_instr[14:12]);
    assign w_is_itype = (i_instr[6:0] == OPC_OP_IMM);

    always_comb begin
        w_bad_shift = 1'b0;
        unique case (w_f3)
            F3_SLLI:      w_bad_shift = (w_f7 != F7_ZERO);
            F3_SRLI_SRAI: w_bad_shift = (w_f7 != F7_ZERO) && (w_f7 != F7_ALT);
            default:      w_bad_shift = 1'b0;
        endcase
    end

    always_comb begin
        o_fields          = '0;
        o_fields.instr    = i_instr;
        o_fields.rs1      = i_instr[19:15];
        o_fields.rd       = i_instr[11:7];
        o_fields.funct3   = w_f3;
        o_fields.imm      = {{20{i_instr[31]}}, i_instr[31:20]};
        o_fields.is_itype = w_is_itype;
        o_fields.illegal  = w_is_itype && w_bad_shift;
    end

endmodule

// File: rtl/i_fetch_decode.sv
// PC holder, single-word imem fetch and OP-IMM decode front end.
// Hands one decoded word at a time to execute over valid/ready.
module i_fetch_decode
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rd,
    output logic [2:0]  dec_funct3,
    output logic [31:0] dec_imm,
    output logic        dec_is_itype,
    output logic        dec_illegal
);

    fetch_state_e r_state;
    fetch_state_e w_nstate;
    logic [31:0]  r_pc;
    logic [31:0]  w_npc;
    logic [31:0]  r_pend;
    logic [31:0]  w_npend;
    logic         r_active;
    dec_t         r_dec;
    dec_t         w_fields;
    dec_t         w_cap;
    logic         w_load;
    logic         w_req;
    logic         w_ack;
    logic [31:0]  w_rpc;

    i_field_decode u_field (
        .i_instr  (imem_rdata),
        .o_fields (w_fields)
    );

    // r_active keeps req low for the first cycle out of reset
    assign w_req = r_active && (r_state != ST_HOLD);
    assign w_ack = imem_ack && w_req;
    assign w_rpc = {redirect_pc[31:2], 2'b00};

    always_comb begin
        w_cap    = w_fields;
        w_cap.pc = r_pc;
    end

    always_comb begin
        w_nstate = r_state;
        w_npc    = r_pc;
        w_npend  = r_pend;
        w_load   = 1'b0;
        unique case (r_state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (w_req && !w_ack) begin
                        w_npend  = w_rpc;
                        w_nstate = ST_DRAIN;
                    end else begin
                        w_npc = w_rpc;
                    end
                end else if (w_ack) begin
                    w_load   = 1'b1;
                    w_nstate = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    w_npend = w_rpc;
                end
                if (w_ack) begin
                    w_npc    = redirect_valid ? w_rpc : r_pend;
                    w_nstate = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_npc    = w_rpc;
                    w_nstate = ST_FETCH;
                end else if (dec_ready) begin
                    w_npc    = r_pc + 32'(PC_STEP);
                    w_nstate = ST_FETCH;
                end
            end
            default: begin
                w_nstate = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_pend   <= RESET_PC;
            r_active <= 1'b0;
            r_dec    <= '0;
        end else begin
            r_state  <= w_nstate;
            r_pc     <= w_npc;
            r_pend   <= w_npend;
            r_active <= 1'b1;
            if (w_load) begin
                r_dec <= w_cap;
            end
        end
    end

    assign imem_req     = w_req;
    assign imem_addr    = r_pc;
    assign dec_valid    = (r_state == ST_HOLD);
    assign dec_pc       = r_dec.pc;
    assign dec_instr    = r_dec.instr;
    assign dec_rs1      = r_dec.rs1;
    assign dec_rd       = r_dec.rd;
    assign dec_funct3   = r_dec.funct3;
    assign dec_imm      = r_dec.imm;
    assign dec_is_itype = r_dec.is_itype;
    assign dec_illegal  = r_dec.illegal;

endmodule
